lcd_text_formatter: RTL

Upstream feeder for the character-LCD driver. It converts two unsigned binary values into right-aligned decimal ASCII fields. It assembles the full 32-character display image (16 chars per line) and presents it on the ascii array. After each new image it pulses update_lcd for one clock. The image is held stable between updates, so the downstream driver can refresh continuously.

---
 rtl/lcd_text_formatter_pkg.sv | 54 +++++
 rtl/lcd_text_formatter_bin_to_bcd_seq.sv | 64 ++++++
 rtl/lcd_text_formatter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lcd_text_formatter_pkg.sv
// Shared constants, state encoding and BCD/ASCII helpers for the LCD text formatter.
package lcd_text_pkg;

  localparam int LINE_LEN  = 16;
  localparam int NUM_CHARS = 32;
  localparam int DIGITS    = 5;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [55:0] LABEL_A     = 56'("VAL A: ");
  localparam logic [55:0] LABEL_B     = 56'("VAL B: ");

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV_A = 3'd1,
    ST_CONV_B = 3'd2,
    ST_FORMAT = 3'd3,
    ST_NOTIFY = 3'd4
  } fmt_state_t;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
    logic [19:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Five ASCII chars, most-significant digit in bits [39:32]; the units digit is never blanked.
  function automatic logic [39:0] bcd_field(input logic [19:0] bcd, input logic blank_lz);
    logic [39:0] f;
    logic        lead;
    logic [3:0]  nib;
    f    = 40'd0;
    lead = blank_lz;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (lead && (nib == 4'd0) && (i != 0)) begin
        f[8*i +: 8] = ASCII_SPACE;
      end else begin
        lead        = 1'b0;
        f[8*i +: 8] = ASCII_ZERO + {4'd0, nib};
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/lcd_text_formatter_bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, WIDTH clocks per value.
// bcd presents the post-step result so the caller can capture it on the cycle done is high.
module bin_to_bcd_seq
  import lcd_text_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] bin,
  output logic             done,
  output logic [19:0]      bcd
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [19:0]      bcd_q, bcd_d, adj_s, step_s;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;

  // One conversion step plus load/advance bookkeeping.
  always_comb begin
    adj_s   = bcd_adjust(bcd_q);
    step_s  = {adj_s[18:0], shift_q[WIDTH-1]};
    done    = busy_q && (count_q == LAST);
    bcd     = step_s;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    busy_d  = busy_q;
    if (load) begin
      shift_d = bin;
      bcd_d   = 20'd0;
      count_d = {CW{1'b0}};
      busy_d  = 1'b1;
    end else if (busy_q) begin
      shift_d = shift_q << 1;
      bcd_d   = step_s;
      count_d = count_q + CW'(1);
      busy_d  = !done;
    end else begin
      busy_d  = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= {WIDTH{1'b0}};
      bcd_q   <= 20'd0;
      count_q <= {CW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/lcd_text_formatter.sv
// Converts two binary values to right-aligned decimal fields and publishes a
// 32-character LCD image, pulsing update_lcd for one clock per new image.
module lcd_text_formatter
  import lcd_text_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value_a,
  input  logic [WIDTH-1:0] value_b,
  output logic             ready,
  output logic             update_lcd,
  output logic [7:0]       ascii [0:NUM_CHARS-1]
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_CONV_A = ST_CONV_A;
  localparam logic [2:0] S_CONV_B = ST_CONV_B;
  localparam logic [2:0] S_FORMAT = ST_FORMAT;
  localparam logic [2:0] S_NOTIFY = ST_NOTIFY;

  logic [2:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             update_q, update_d;
  logic [WIDTH-1:0] hold_b_q, hold_b_d;
  logic [19:0]      digits_a_q, digits_a_d;
  logic [19:0]      digits_b_q, digits_b_d;
  logic [7:0]       ascii_q [0:NUM_CHARS-1];
  logic [7:0]       image_s [0:NUM_CHARS-1];
  logic [39:0]      field_a_s, field_b_s;
  logic             eng_load_s, eng_done_s, fmt_en_s;
  logic [WIDTH-1:0] eng_bin_s;
  logic [19:0]      eng_bcd_s;

  bin_to_bcd_seq #(.WIDTH(WIDTH)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .load  (eng_load_s),
    .bin   (eng_bin_s),
    .done  (eng_done_s),
    .bcd   (eng_bcd_s)
  );

  // Sequencing: one shared converter runs A then B, then the image is formatted.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    update_d   = 1'b0;
    hold_b_d   = hold_b_q;
    digits_a_d = digits_a_q;
    digits_b_d = digits_b_q;
    eng_load_s = 1'b0;
    eng_bin_s  = value_a;
    fmt_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          eng_load_s = 1'b1;
          hold_b_d   = value_b;
          ready_d    = 1'b0;
          state_d    = S_CONV_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV_A: begin
        if (eng_done_s) begin
          digits_a_d = eng_bcd_s;
          eng_load_s = 1'b1;
          eng_bin_s  = hold_b_q;
          state_d    = S_CONV_B;
        end else begin
          state_d = S_CONV_A;
        end
      end
      S_CONV_B: begin
        if (eng_done_s) begin
          digits_b_d = eng_bcd_s;
          state_d    = S_FORMAT;
        end else begin
          state_d = S_CONV_B;
        end
      end
      S_FORMAT: begin
        fmt_en_s = 1'b1;
        update_d = 1'b1;
        state_d  = S_NOTIFY;
      end
      S_NOTIFY: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Full display image built from the latched digits; only registered on FORMAT.
  always_comb begin
    field_a_s = bcd_field(digits_a_q, BLANK_LZ);
    field_b_s = bcd_field(digits_b_q, BLANK_LZ);
    for (int i = 0; i < NUM_CHARS; i++) begin
      image_s[i] = ASCII_SPACE;
    end
    for (int i = 0; i < 7; i++) begin
      image_s[i]            = LABEL_A[8*(6-i) +: 8];
      image_s[LINE_LEN + i] = LABEL_B[8*(6-i) +: 8];
    end
    for (int i = 0; i < DIGITS; i++) begin
      image_s[7 + i]            = field_a_s[8*(DIGITS-1-i) +: 8];
      image_s[LINE_LEN + 7 + i] = field_b_s[8*(DIGITS-1-i) +: 8];
    end
  end

  // Control, digit latches and the published image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      update_q   <= 1'b0;
      hold_b_q   <= {WIDTH{1'b0}};
      digits_a_q <= 20'd0;
      digits_b_q <= 20'd0;
      for (int i = 0; i < NUM_CHARS; i++) begin
        ascii_q[i] <= ASCII_SPACE;
      end
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      update_q   <= update_d;
      hold_b_q   <= hold_b_d;
      digits_a_q <= digits_a_d;
      digits_b_q <= digits_b_d;
      if (fmt_en_s) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
          ascii_q[i] <= image_s[i];
        end
      end
    end
  end

  assign ready      = ready_q;
  assign update_lcd = update_q;
  assign ascii      = ascii_q;

endmodule
